// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants (640x480@60 Hz, 25 MHz pixel clock).
// The colour logic imports the same values so both sides agree on the raster.
package vga_timing_pkg;

  localparam int unsigned COUNT_W   = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Active level of both sync pulses; 0 means active-low.
  localparam bit SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrap counter plus registered sync-window decode.
// Sync is decoded from the next count so it lines up with the count it describes.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = H_VISIBLE,
  parameter int unsigned FRONT    = H_FRONT,
  parameter int unsigned SYNC     = H_SYNC,
  parameter int unsigned BACK     = H_BACK,
  parameter bit          POL      = SYNC_POL,
  parameter int unsigned W        = COUNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         wrap,
  output logic         visible_next
);

  localparam logic [W-1:0] LAST       = W'(VISIBLE + FRONT + SYNC + BACK - 1);
  localparam logic [W-1:0] SYNC_START = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_END   = W'(VISIBLE + FRONT + SYNC);
  localparam logic [W-1:0] VIS_END    = W'(VISIBLE);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;

  always_comb begin
    count_d      = count_q;
    wrap         = 1'b0;
    sync_d       = ~POL;
    visible_next = 1'b0;
    if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
    if ((count_d >= SYNC_START) && (count_d < SYNC_END)) begin
      sync_d = POL;
    end
    visible_next = (count_d < VIS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/hv_sync_generator.sv
// VGA raster timing generator: pixel/line counters, h/v sync and visible flag.
// Every output is a register aligned with the counters of the same cycle.
module hv_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned HV  = H_VISIBLE,
  parameter int unsigned HF  = H_FRONT,
  parameter int unsigned HS  = H_SYNC,
  parameter int unsigned HB  = H_BACK,
  parameter int unsigned VV  = V_VISIBLE,
  parameter int unsigned VF  = V_FRONT,
  parameter int unsigned VS  = V_SYNC,
  parameter int unsigned VB  = V_BACK,
  parameter bit          POL = SYNC_POL
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 vga_h_sync,
  output logic                 vga_v_sync,
  output logic                 inDisplayArea,
  output logic [COUNT_W-1:0]   CounterX,
  output logic [COUNT_W-1:0]   CounterY
);

  logic x_wrap, y_wrap;
  logic x_vis_next, y_vis_next;
  logic in_display_q, in_display_d;

  vga_axis_timer #(
    .VISIBLE(HV), .FRONT(HF), .SYNC(HS), .BACK(HB), .POL(POL), .W(COUNT_W)
  ) u_x (
    .clk          (clk),
    .reset        (reset),
    .en           (1'b1),
    .count        (CounterX),
    .sync         (vga_h_sync),
    .wrap         (x_wrap),
    .visible_next (x_vis_next)
  );

  // Y advances only on the X wrap, so v sync changes exactly at line boundaries.
  vga_axis_timer #(
    .VISIBLE(VV), .FRONT(VF), .SYNC(VS), .BACK(VB), .POL(POL), .W(COUNT_W)
  ) u_y (
    .clk          (clk),
    .reset        (reset),
    .en           (x_wrap),
    .count        (CounterY),
    .sync         (vga_v_sync),
    .wrap         (y_wrap),
    .visible_next (y_vis_next)
  );

  always_comb begin
    in_display_d = x_vis_next && y_vis_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_display_q <= 1'b0;
    end else begin
      in_display_q <= in_display_d;
    end
  end

  assign inDisplayArea = in_display_q;

endmodule

// File: tb/tb_hv_sync_generator.sv
// Directed bench: default-timing instance for line-level checks, plus a
// shrunken-timing instance so whole frames fit in a short run.
module tb_hv_sync_generator;

  logic       clk = 1'b0;
  logic       rst_d = 1'b0;
  logic       rst_s = 1'b0;

  logic       d_hs, d_vs, d_disp;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_disp;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hv_sync_generator dut (
    .clk           (clk),
    .reset         (rst_d),
    .vga_h_sync    (d_hs),
    .vga_v_sync    (d_vs),
    .inDisplayArea (d_disp),
    .CounterX      (d_x),
    .CounterY      (d_y)
  );

  // Small raster: H 8+2+3+2=15 (hs at X 10..12), V 4+1+2+2=9 (vs at Y 5..6).
  hv_sync_generator #(
    .HV(8), .HF(2), .HS(3), .HB(2),
    .VV(4), .VF(1), .VS(2), .VB(2), .POL(1'b0)
  ) dus (
    .clk           (clk),
    .reset         (rst_s),
    .vga_h_sync    (s_hs),
    .vga_v_sync    (s_vs),
    .inDisplayArea (s_disp),
    .CounterX      (s_x),
    .CounterY      (s_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low;
    int ex, ey, cyc, last_fall, vs_low;
    logic prev_vs;

    // Reset held for 10 clocks on both instances.
    repeat (10) @(negedge clk);
    chk("rst_x",    32'(d_x), 0);
    chk("rst_y",    32'(d_y), 0);
    chk("rst_hs",   32'(d_hs), 1);
    chk("rst_vs",   32'(d_vs), 1);
    chk("rst_disp", 32'(d_disp), 0);
    chk("s_rst_x",  32'(s_x), 0);
    chk("s_rst_vs", 32'(s_vs), 1);

    // Release: first edge gives X=1 and the visible flag.
    rst_d = 1'b1;
    @(negedge clk);
    chk("rel_x",    32'(d_x), 1);
    chk("rel_y",    32'(d_y), 0);
    chk("rel_disp", 32'(d_disp), 1);
    chk("rel_hs",   32'(d_hs), 1);

    // Line 0 scan: hs window 656..751, visible below 640.
    hs_low = 0;
    for (int k = 2; k < 800; k++) begin
      @(negedge clk);
      chk("line_x",    32'(d_x), 32'(k));
      chk("line_y",    32'(d_y), 0);
      chk("line_hs",   32'(d_hs), (k >= 656 && k <= 751) ? 0 : 1);
      chk("line_disp", 32'(d_disp), (k < 640) ? 1 : 0);
      chk("line_vs",   32'(d_vs), 1);
      if (d_hs == 1'b0) hs_low++;
    end
    chk("hs_width", 32'(hs_low), 96);

    @(negedge clk);
    chk("xwrap_x",    32'(d_x), 0);
    chk("xwrap_y",    32'(d_y), 1);
    chk("xwrap_disp", 32'(d_disp), 1);

    repeat (300) @(negedge clk);
    chk("mid_x", 32'(d_x), 300);
    chk("mid_y", 32'(d_y), 1);

    // Asynchronous reset between edges.
    #2 rst_d = 1'b0;
    #1;
    chk("arst_x",    32'(d_x), 0);
    chk("arst_y",    32'(d_y), 0);
    chk("arst_hs",   32'(d_hs), 1);
    chk("arst_disp", 32'(d_disp), 0);
    @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    chk("rest_x", 32'(d_x), 1);
    chk("rest_y", 32'(d_y), 0);

    // Small instance: three whole frames against a reference counter.
    rst_s = 1'b1;
    ex = 0; ey = 0; cyc = 0; last_fall = -1; vs_low = 0; prev_vs = 1'b1;
    for (int n = 0; n < 405; n++) begin
      @(negedge clk);
      cyc++;
      if (ex == 14) begin
        ex = 0;
        ey = (ey == 8) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      chk("s_x",    32'(s_x), 32'(ex));
      chk("s_y",    32'(s_y), 32'(ey));
      chk("s_hs",   32'(s_hs), (ex >= 10 && ex <= 12) ? 0 : 1);
      chk("s_vs",   32'(s_vs), (ey >= 5 && ey <= 6) ? 0 : 1);
      chk("s_disp", 32'(s_disp), (ex < 8 && ey < 4) ? 1 : 0);
      if (prev_vs && !s_vs) begin
        if (last_fall >= 0) chk("s_vs_period", 32'(cyc - last_fall), 135);
        last_fall = cyc;
      end
      prev_vs = s_vs;
      if (s_vs == 1'b0) vs_low++;
    end
    chk("s_vs_low", 32'(vs_low), 90);
    chk("s_frame_wrap_x", 32'(s_x), 0);
    chk("s_frame_wrap_y", 32'(s_y), 0);

    repeat (50) @(negedge clk);
    chk("s_mid_x", 32'(s_x), 5);
    chk("s_mid_y", 32'(s_y), 3);
    #2 rst_s = 1'b0;
    #1;
    chk("s_arst_x",  32'(s_x), 0);
    chk("s_arst_y",  32'(s_y), 0);
    chk("s_arst_hs", 32'(s_hs), 1);
    chk("s_arst_vs", 32'(s_vs), 1);
    @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    chk("s_rest_x",    32'(s_x), 1);
    chk("s_rest_y",    32'(s_y), 0);
    chk("s_rest_disp", 32'(s_disp), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
